fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drain stage that sits directly downstream of the synchronous FIFO. It issues `rd_en` to the FIFO, captures the registered `data_out` one cycle later, and presents words on a valid/ready stream. A 3-entry skid buffer absorbs the FIFO read latency, so the block sustains one word per cycle under continuous `m_ready` with no combinational path from `m_ready` to `fifo_rd_en`.

## Interface
- `FIFO_WIDTH`, 16, data word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high permits new FIFO reads; low starts a flush.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag, asserted the cycle after a read of an empty FIFO.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_data`  out  FIFO_WIDTH  head word of the skid buffer.
- `m_valid`  out  1  skid buffer is non-empty.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `busy`  out  1  state is not IDLE.
- `rd_count`  out  CNT_WIDTH  count of words accepted (`m_valid && m_ready`); wraps.
- `err_underflow`  out  1  sticky; set when a returned word is discarded because of underflow.

## Operation
- Registered state: FSM state, `inflight` (1 bit: `fifo_rd_en` was high last cycle), skid buffer of 3 entries with write pointer, read pointer and `occ` (0..3).
- FSM states and transitions:
  - IDLE → RUN when `enable` is high.
  - RUN → FLUSH when `enable` is low.
  - FLUSH → RUN when `enable` is high.
  - FLUSH → IDLE when `inflight == 0` and `occ == 0`.
- `fifo_rd_en` = (state == RUN) && !`fifo_empty` && (`occ` + `inflight` < 3). It is combinational from registers and the FIFO's registered `fifo_empty` only.
- Capture: when `inflight` is set, `fifo_data_out` is written to the buffer tail at the cycle end, unless `fifo_underflow` is high that cycle. In that case the word is dropped, `occ` is unchanged and `err_underflow` is set.
- Pop: `m_valid && m_ready` advances the read pointer and increments `rd_count`.
- A push and a pop in the same cycle leave `occ` unchanged. Pointers wrap modulo 3.
- The credit rule guarantees a capture never meets a full buffer. The bench asserts `occ` never exceeds 3.
- `m_data` and `m_valid` hold stable while `m_valid && !m_ready`.
- Reset mid-operation: all state clears asynchronously. An in-flight word is discarded; the FIFO is not re-read.

## Timing
- Reset values:
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0.
  - `rd_count` = 0, `err_underflow` = 0, state IDLE, `occ` = 0, `inflight` = 0.
- First word: `enable` rises in cycle 0 (FIFO non-empty). State is RUN in cycle 1, `fifo_rd_en` is high in cycle 1, data is captured at the end of cycle 2, and `m_valid` is high in cycle 3.
- Steady state, with `m_ready` held high and the FIFO non-empty: `fifo_rd_en` stays high and `m_valid` stays high every cycle, giving 1 word/cycle.
- When `m_ready` is low, reads stop after the buffer plus in-flight slot reaches 3 words.
- When the FIFO goes empty, `fifo_rd_en` drops in the same cycle `fifo_empty` is high. There are no speculative reads.

## Configuration
- `FIFO_RD_PARITY_EN`:
  - Defined: adds output `m_parity` (1 bit), the even parity (XOR reduction) of `m_data`. It is computed at capture and stored per buffer entry (width FIFO_WIDTH+1), and resets to 0.
  - Undefined: the port and the storage bit are absent, and behaviour is otherwise identical.

## Structure
- Shared package `fifo_rd_pkg`:
  - state enum `rd_state_e` {IDLE, RUN, FLUSH}.
  - localparam `SKID_DEPTH` = 3.
  - pointer/occupancy width constants.
- One natural sub-module, `skid_buf3`: 3-entry register buffer with push/pop, `occ`, and head output. The FSM and credit logic live in the top level.

## Test plan
- Back-to-back drain: FIFO preloaded with 0x0001..0x0008, `enable`=1, `m_ready`=1 → 8 words in order on consecutive cycles starting at cycle 3; `rd_count`=8; FSM returns to RUN-idle with `fifo_rd_en`=0.
- Backpressure: 8 words loaded, `m_ready`=0 for 10 cycles → exactly 3 `fifo_rd_en` pulses and `m_data`=0x0001 held stable; then `m_ready`=1 → remaining 7 words in order, none lost.
- Flush: `enable` drops while 1 read is in flight and `occ`=2 → no further `fifo_rd_en`, 3 words delivered, then IDLE with `busy`=0.
- Underflow injection: force `fifo_underflow`=1 in the capture cycle of word 0x0005 → word dropped, `err_underflow`=1 and sticky, `rd_count` ends at 7.
- Reset mid-stream: `rst_n` low for 1 cycle with `occ`=2 → all outputs at reset values immediately, `rd_count`=0; after release with `enable` high, the drain resumes from the FIFO's next word.
- With `FIFO_RD_PARITY_EN`: words 0x0003 and 0x0007 → `m_parity`=0, then 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CREDIT_W   = 3;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// 3-entry register skid buffer with push/pop, occupancy and head output.
module skid_buf3
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [W-1:0]     mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (occ_q != '0);
  assign do_push = push_i && ((occ_q != OCC_W'(SKID_DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream through a 3-entry skid buffer.
// Optional FIFO_RD_PARITY_EN adds a stored per-word even-parity output m_parity.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

`ifdef FIFO_RD_PARITY_EN
  localparam int unsigned EW = FIFO_WIDTH + 1;
`else
  localparam int unsigned EW = FIFO_WIDTH;
`endif

  rd_state_e             state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  err_q, err_d;
  logic [OCC_W-1:0]      occ;
  logic [CREDIT_W-1:0]   credit_used;
  logic [EW-1:0]         buf_wdata;
  logic [EW-1:0]         buf_head;
  logic                  push;
  logic                  pop;

  // Words in the buffer plus the one possibly returning this cycle bound new reads.
  assign credit_used = CREDIT_W'(occ) + CREDIT_W'(inflight_q);
  assign fifo_rd_en  = (state_q == RUN) && !fifo_empty && (credit_used < CREDIT_W'(SKID_DEPTH));
  assign push        = inflight_q && !fifo_underflow;
  assign m_valid     = (occ != '0);
  assign pop         = m_valid && m_ready;

`ifdef FIFO_RD_PARITY_EN
  assign buf_wdata = {^fifo_data_out, fifo_data_out};
  assign m_parity  = buf_head[FIFO_WIDTH];
`else
  assign buf_wdata = fifo_data_out;
`endif
  assign m_data = buf_head[FIFO_WIDTH-1:0];

  skid_buf3 #(.W(EW)) u_buf (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .wdata_i(buf_wdata),
    .pop_i  (pop),
    .head_o (buf_head),
    .occ_o  (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inflight_d = fifo_rd_en;
    rd_count_d = rd_count_q;
    err_d      = err_q;
    busy       = (state_q != IDLE);

    if (pop) rd_count_d = rd_count_q + 1'b1;
    if (inflight_q && fifo_underflow) err_d = 1'b1;

    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = FLUSH;
      FLUSH: begin
        if (enable) state_d = RUN;
        else if (!inflight_q && (occ == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_count      = rd_count_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [15:0] rd_count;
  logic        err_underflow;
`ifdef FIFO_RD_PARITY_EN
  logic        m_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] fq[$];
  logic [15:0] got[$];
  logic        gotp[$];
  logic        rd_en_s = 1'b0;
  logic        inj_en = 1'b0;
  logic [15:0] inj_word = '0;
  logic [15:0] mw;

  int pulses = 0, drops = 0, pending = 0, occ_viol = 0, stab_viol = 0;
  logic prev_rd = 1'b0, prev_hold = 1'b0, acc;
  logic [15:0] hold_data = '0;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .rd_count      (rd_count),
    .err_underflow (err_underflow)
`ifdef FIFO_RD_PARITY_EN
    ,
    .m_parity      (m_parity)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered data/empty/underflow, read request sampled just before the edge.
  always @(posedge clk) begin
    if (rd_en_s) begin
      if (fq.size() != 0) begin
        mw = fq.pop_front();
        fifo_data_out  <= mw;
        fifo_underflow <= inj_en && (mw == inj_word);
      end else begin
        fifo_underflow <= 1'b1;
      end
    end else begin
      fifo_underflow <= 1'b0;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Stream monitor sampling late in each cycle.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      pending = 0; prev_rd = 1'b0; prev_hold = 1'b0;
    end else begin
      acc = m_valid && m_ready;
      if (prev_rd && fifo_underflow) drops++;
      if (prev_hold && (m_valid !== 1'b1 || m_data !== hold_data)) stab_viol++;
      if (fifo_rd_en) pulses++;
      if (acc) begin
        got.push_back(m_data);
`ifdef FIFO_RD_PARITY_EN
        gotp.push_back(m_parity);
`endif
      end
      pending = pending + int'(fifo_rd_en) - int'(acc) - int'(prev_rd && fifo_underflow);
      if (pending > 3 || pending < 0) occ_viol++;
      prev_rd   = fifo_rd_en;
      prev_hold = m_valid && !m_ready;
      hold_data = m_data;
    end
    rd_en_s = fifo_rd_en && rst_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; inj_en = 1'b0;
    fq.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(16'(base + i));
    tick(); tick();
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b expected 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b expected 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL rst_rd_count: got %0d expected 0", rd_count); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b expected 0", err_underflow); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int pb, first, n;
    apply_reset();
    load(8, 1);
    m_ready = 1'b1;
    pb = pulses; first = -1; n = 0;
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (fifo_rd_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_cycle1: got rd_en=%0b busy=%0b expected 1 1", fifo_rd_en, busy); end
      end
      if (m_valid && m_ready) begin
        if (first < 0) first = c;
        checks++; if (m_data !== 16'(n + 1) || c != first + n) begin errors++; $display("FAIL b2b_word: got %0h at cycle %0d expected %0h at cycle %0d", m_data, c, n + 1, first + n); end
        n++;
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 3", first); end
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_word_count: got %0d expected 8", n); end
    checks++; if (rd_count !== 16'd8) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 8", rd_count); end
    checks++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_state: got busy=%0b rd_en=%0b valid=%0b expected 1 0 0", busy, fifo_rd_en, m_valid); end
    checks++; if (pulses - pb != 8) begin errors++; $display("FAIL b2b_pulses: got %0d expected 8", pulses - pb); end
  endtask

  task automatic test_backpressure();
    int pb, sb, gb, bad, w;
    apply_reset();
    load(8, 1);
    pb = pulses; sb = stab_viol;
    enable = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    checks++; if (pulses - pb != 3) begin errors++; $display("FAIL bp_pulses: got %0d expected 3", pulses - pb); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL bp_head: got valid=%0b data=%0h expected 1 0001", m_valid, m_data); end
    checks++; if (stab_viol != sb) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol - sb); end
    gb = got.size();
    m_ready = 1'b1;
    w = 0;
    while (got.size() - gb < 8 && w < 40) begin tick(); w++; end
    bad = 0;
    for (int i = 0; i < 8 && gb + i < got.size(); i++) if (got[gb + i] !== 16'(i + 1)) bad++;
    checks++; if (got.size() - gb != 8 || bad != 0) begin errors++; $display("FAIL bp_words: got %0d words (%0d wrong) expected 8 in order", got.size() - gb, bad); end
    tick();
    checks++; if (rd_count !== 16'd8) begin errors++; $display("FAIL bp_rd_count: got %0d expected 8", rd_count); end
  endtask

  task automatic test_flush();
    int pb, gb, w, bad;
    apply_reset();
    load(8, 1);
    pb = pulses; gb = got.size();
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    checks++; if (pulses - pb != 3 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL fl_pre: got pulses=%0d rd_en=%0b expected 3 0", pulses - pb, fifo_rd_en); end
    enable = 1'b0;
    m_ready = 1'b1;
    w = 0;
    tick();
    while (busy && w < 30) begin tick(); w++; end
    tick();
    bad = 0;
    for (int i = 0; i < 3 && gb + i < got.size(); i++) if (got[gb + i] !== 16'(i + 1)) bad++;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL fl_idle: got busy=%0b valid=%0b expected 0 0", busy, m_valid); end
    checks++; if (pulses - pb != 3) begin errors++; $display("FAIL fl_pulses: got %0d expected 3", pulses - pb); end
    checks++; if (got.size() - gb != 3 || bad != 0) begin errors++; $display("FAIL fl_words: got %0d words (%0d wrong) expected 3", got.size() - gb, bad); end
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL fl_rd_count: got %0d expected 3", rd_count); end
  endtask

  task automatic test_underflow();
    int gb, db, bad;
    logic [15:0] exp[$];
    apply_reset();
    load(8, 1);
    for (int v = 1; v <= 8; v++) if (v != 5) exp.push_back(16'(v));
    gb = got.size(); db = drops;
    inj_word = 16'h0005; inj_en = 1'b1;
    m_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    bad = 0;
    for (int i = 0; i < exp.size() && gb + i < got.size(); i++) if (got[gb + i] !== exp[i]) bad++;
    checks++; if (got.size() - gb != 7 || bad != 0) begin errors++; $display("FAIL uf_words: got %0d words (%0d wrong) expected 7", got.size() - gb, bad); end
    checks++; if (rd_count !== 16'd7) begin errors++; $display("FAIL uf_rd_count: got %0d expected 7", rd_count); end
    checks++; if (err_underflow !== 1'b1 || drops - db != 1) begin errors++; $display("FAIL uf_err: got err=%0b drops=%0d expected 1 1", err_underflow, drops - db); end
    inj_en = 1'b0;
    enable = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %0b expected 1", err_underflow); end
  endtask

  task automatic test_reset_midstream();
    int gb, bad;
    apply_reset();
    load(8, 1);
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL rm_pre: got valid=%0b data=%0h expected 1 0001", m_valid, m_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_outputs: got rd_en=%0b valid=%0b data=%0h busy=%0b expected 0 0 0 0", fifo_rd_en, m_valid, m_data, busy); end
    checks++; if (rd_count !== 16'h0 || err_underflow !== 1'b0) begin errors++; $display("FAIL rm_counters: got rd_count=%0d err=%0b expected 0 0", rd_count, err_underflow); end
    gb = got.size();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 25; c++) tick();
    bad = 0;
    for (int i = 0; i < 5 && gb + i < got.size(); i++) if (got[gb + i] !== 16'(i + 4)) bad++;
    checks++; if (got.size() - gb != 5 || bad != 0) begin errors++; $display("FAIL rm_resume: got %0d words (%0d wrong) expected 5 from 0004", got.size() - gb, bad); end
    checks++; if (rd_count !== 16'd5) begin errors++; $display("FAIL rm_rd_count: got %0d expected 5", rd_count); end
  endtask

  task automatic test_random();
    int gb, pushed, w, bad, n;
    logic [15:0] exp[$];
    logic [15:0] v;
    apply_reset();
    gb = got.size(); pushed = 0; w = 0; n = 40;
    enable = 1'b1;
    while ((pushed < n || got.size() - gb < n) && w < 3000) begin
      if (pushed < n && $urandom_range(0, 2) != 0) begin
        v = 16'($urandom);
        fq.push_back(v); exp.push_back(v); pushed++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick(); w++;
    end
    m_ready = 1'b1;
    tick(); tick();
    bad = 0;
    for (int i = 0; i < exp.size() && gb + i < got.size(); i++) if (got[gb + i] !== exp[i]) bad++;
    checks++; if (got.size() - gb != n || bad != 0) begin errors++; $display("FAIL rnd_words: got %0d words (%0d wrong) expected %0d", got.size() - gb, bad, n); end
    checks++; if (rd_count !== 16'(n)) begin errors++; $display("FAIL rnd_rd_count: got %0d expected %0d", rd_count, n); end
    checks++; if (occ_viol != 0) begin errors++; $display("FAIL rnd_occupancy: got %0d cycles over 3 expected 0", occ_viol); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rnd_stable: got %0d hold violations expected 0", stab_viol); end
  endtask

`ifdef FIFO_RD_PARITY_EN
  task automatic test_parity();
    int gb;
    logic e0, e1;
    apply_reset();
    gb = gotp.size();
    fq.push_back(16'h0003); fq.push_back(16'h0007);
    tick(); tick();
    e0 = ($countones(16'h0003) % 2) == 1;
    e1 = ($countones(16'h0007) % 2) == 1;
    m_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    checks++; if (gotp.size() - gb != 2) begin errors++; $display("FAIL par_count: got %0d expected 2", gotp.size() - gb); end
    else begin
      checks++; if (gotp[gb] !== e0) begin errors++; $display("FAIL par_w3: got %0b expected %0b", gotp[gb], e0); end
      checks++; if (gotp[gb + 1] !== e1) begin errors++; $display("FAIL par_w7: got %0b expected %0b", gotp[gb + 1], e1); end
    end
  endtask
`endif

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_underflow();
    test_reset_midstream();
    test_random();
`ifdef FIFO_RD_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
